// File: rtl/ft_frame_tx_if.sv
// Pixel-in / byte-out handshake bundle for ft_frame_tx.
// master = packetiser side, slave = pixel source and FT byte sink side.
interface ft_frame_tx_if;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [7:0]  write_data;
   logic        write;
   logic        wr_ready;

   modport master (
      input  in_data, in_valid, in_sof, wr_ready,
      output in_ready, write_data, write
   );

   modport slave (
      output in_data, in_valid, in_sof, wr_ready,
      input  in_ready, write_data, write
   );
endinterface

// File: rtl/ft_frame_tx.sv
// Frame packetiser: 4-byte header, then RGB565 / GRAY8 / test-pattern payload,
// zero-padded so every frame has a constant byte count.
module ft_frame_tx #(
   parameter int unsigned IM_X      = 1280,
   parameter int unsigned IM_Y      = 720,
   parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    cmd_data,
   input  logic          cmd_valid,
   input  logic [1:0]    mode,
   ft_frame_tx_if.master bus,
   output logic          streaming,
   output logic [7:0]    frame_cnt,
   output logic          sof_err
);
   localparam int unsigned XW = (IM_X > 1) ? $clog2(IM_X) : 1;
   localparam int unsigned YW = (IM_Y > 1) ? $clog2(IM_Y) : 1;
   localparam int unsigned BW = $clog2(IM_X * IM_Y * 2 + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_HDR, S_PIX, S_PAD, S_END} state_t;
   state_t state, state_nx;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          phase;
   logic [1:0]    hdr_idx;
   logic [BW-1:0] byte_left;
   logic [1:0]    mode_q;
   logic          active, cont, stop_pend;
   logic          can_load, first_pix, sof_seen, premature;
   logic          load, consume, ready_c;
   logic [7:0]    load_data, r8, g8, b8;
   logic [15:0]   ysum;

   assign can_load  = !bus.write || bus.wr_ready;
   assign first_pix = (x == '0) && (y == '0);
   assign sof_seen  = bus.in_valid && bus.in_sof;
   assign premature = sof_seen && !first_pix && !phase;

   assign r8   = {bus.in_data[15:11], bus.in_data[15:13]};
   assign g8   = {bus.in_data[10:5],  bus.in_data[10:9]};
   assign b8   = {bus.in_data[4:0],   bus.in_data[4:2]};
   assign ysum = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;

   // Held at 0 through reset even though IDLE would otherwise accept.
   assign bus.in_ready = rst_n && ready_c;

   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      load_data = '0;
      consume   = 1'b0;
      ready_c   = 1'b0;
      case (state)
         S_IDLE: begin
            ready_c = 1'b1;
            if (active && !stop_pend) state_nx = S_WAIT_SOF;
         end
         S_WAIT_SOF: begin
            ready_c = !sof_seen;
            if (stop_pend)     state_nx = S_IDLE;
            else if (sof_seen) state_nx = S_HDR;
         end
         S_HDR: begin
            if (can_load) begin
               load = 1'b1;
               case (hdr_idx)
                  2'd0:    load_data = SYNC_WORD[15:8];
                  2'd1:    load_data = SYNC_WORD[7:0];
                  2'd2:    load_data = frame_cnt;
                  default: load_data = {6'b0, mode_q};
               endcase
               if (hdr_idx == 2'd3) state_nx = S_PIX;
            end
         end
         S_PIX: begin
            // A pixel is consumed only together with its last output byte.
            ready_c = can_load && !premature && (mode_q != 2'd0 || phase);
            if (premature) begin
               state_nx = S_PAD;
            end else if (can_load && bus.in_valid) begin
               load    = 1'b1;
               consume = ready_c;
               case (mode_q)
                  2'd0:    load_data = phase ? bus.in_data[7:0] : bus.in_data[15:8];
                  2'd1:    load_data = ysum[15:8];
                  default: load_data = 8'(x) ^ 8'(y);
               endcase
               if (byte_left == BW'(1)) state_nx = S_PAD;
            end
         end
         S_PAD: begin
            if (byte_left != '0) begin
               load = can_load;
            end else if (can_load) begin
               state_nx = S_END;
            end
         end
         S_END: state_nx = (cont && !stop_pend) ? S_WAIT_SOF : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.write      <= 1'b0;
         bus.write_data <= '0;
         x              <= '0;
         y              <= '0;
         phase          <= 1'b0;
         hdr_idx        <= '0;
         byte_left      <= '0;
         mode_q         <= '0;
         active         <= 1'b0;
         cont           <= 1'b0;
         stop_pend      <= 1'b0;
         frame_cnt      <= '0;
         sof_err        <= 1'b0;
         streaming      <= 1'b0;
      end else begin
         if (load) begin
            bus.write      <= 1'b1;
            bus.write_data <= load_data;
         end else if (bus.wr_ready) begin
            bus.write <= 1'b0;
         end

         if (state == S_WAIT_SOF && state_nx == S_HDR) begin
            mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
            hdr_idx   <= '0;
            x         <= '0;
            y         <= '0;
            phase     <= 1'b0;
            byte_left <= (mode == 2'd1 || mode == 2'd2) ? BW'(IM_X * IM_Y) : BW'(IM_X * IM_Y * 2);
         end
         if (state == S_HDR && load) hdr_idx <= hdr_idx + 2'd1;
         if ((state == S_PIX || state == S_PAD) && load) byte_left <= byte_left - BW'(1);
         if (state == S_PIX && load && mode_q == 2'd0) phase <= !phase;
         if (consume) begin
            if (x == XW'(IM_X - 1)) begin
               x <= '0;
               y <= (y == YW'(IM_Y - 1)) ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end

         if (state == S_PIX && premature) sof_err <= 1'b1;
         if (state == S_END) frame_cnt <= frame_cnt + 8'd1;

         if (state_nx == S_HDR && state != S_HDR) streaming <= 1'b1;
         else if (state_nx == S_IDLE)             streaming <= 1'b0;

         if (state != S_IDLE && state_nx == S_IDLE) begin
            active    <= 1'b0;
            stop_pend <= 1'b0;
         end
         // Commands land after the flag updates above, so one seen during END applies afterwards.
         if (cmd_valid) begin
            case (cmd_data)
               8'h01: begin active <= 1'b1; cont <= 1'b1; stop_pend <= 1'b0; end
               8'h02: begin active <= 1'b1; cont <= 1'b0; stop_pend <= 1'b0; end
               8'h00: stop_pend <= 1'b1;
               8'h03: sof_err   <= 1'b0;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ft_frame_tx.sv
// Bench for ft_frame_tx on a 4x2 image: random pixels and wr_ready stalls,
// compared with a frame model built from the byte-format rules.
module tb_ft_frame_tx;
   localparam int unsigned IM_X = 4;
   localparam int unsigned IM_Y = 2;
   typedef logic [15:0] pix_q_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       cmd_valid = 1'b0;
   logic [1:0] mode = '0;
   logic       streaming, sof_err;
   logic [7:0] frame_cnt;

   ft_frame_tx_if bus();

   ft_frame_tx #(.IM_X(IM_X), .IM_Y(IM_Y), .SYNC_WORD(16'hA55A)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .mode(mode), .bus(bus), .streaming(streaming), .frame_cnt(frame_cnt),
      .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          exp_fc = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   int          got_t[$];
   logic [16:0] src_q[$];
   bit          fire_seen = 1'b0;
   bit          rdy_rand = 1'b0;

   // Pixel source and wr_ready driver, updated just after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (fire_seen && src_q.size() > 0) void'(src_q.pop_front());
      fire_seen = 1'b0;
      if (src_q.size() > 0) begin
         bus.in_valid = 1'b1;
         bus.in_sof   = src_q[0][16];
         bus.in_data  = src_q[0][15:0];
      end else begin
         bus.in_valid = 1'b0;
         bus.in_sof   = 1'b0;
         bus.in_data  = '0;
      end
      bus.wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      fire_seen = rst_n && bus.in_valid && bus.in_ready;
      if (rst_n && bus.write && bus.wr_ready) begin
         got_q.push_back(bus.write_data);
         got_t.push_back(cyc);
      end
   end

   task automatic send_cmd(input logic [7:0] c);
      @(posedge clk); #2;
      cmd_valid = 1'b1;
      cmd_data  = c;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
   endtask

   task automatic push_frame(input pix_q_t px);
      foreach (px[i]) src_q.push_back({(i == 0), px[i]});
   endtask

   task automatic rand_frame(output pix_q_t px);
      px = {};
      for (int i = 0; i < int'(IM_X * IM_Y); i++) px.push_back(16'($urandom));
   endtask

   // Expected bytes of one frame: header, payload for the pixels given, zero pad.
   task automatic model_frame(input int m, input pix_q_t px);
      int start, total, v, r5, g6, b5, r8, g8, b8;
      start = exp_q.size();
      total = 4 + int'(IM_X * IM_Y) * ((m == 0) ? 2 : 1);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(exp_fc));
      exp_q.push_back(8'(m));
      foreach (px[i]) begin
         v  = int'(px[i]);
         r5 = (v / 2048) % 32;
         g6 = (v / 32) % 64;
         b5 = v % 32;
         r8 = r5 * 8 + r5 / 4;
         g8 = g6 * 4 + g6 / 16;
         b8 = b5 * 8 + b5 / 4;
         case (m)
            0: begin
               exp_q.push_back(8'(v / 256));
               exp_q.push_back(8'(v % 256));
            end
            1:       exp_q.push_back(8'((77 * r8 + 150 * g8 + 29 * b8) / 256));
            default: exp_q.push_back(8'((i % int'(IM_X)) ^ (i / int'(IM_X))));
         endcase
      end
      while (exp_q.size() < start + total) exp_q.push_back(8'h00);
      exp_fc = (exp_fc + 1) % 256;
   endtask

   task automatic wait_bytes(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk); #1;
         if (got_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.wr_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.write !== 1'b0)      begin errors++; $display("FAIL rst_write: got %b expected 0", bus.write); end
      checks++; if (bus.write_data !== 8'h00) begin errors++; $display("FAIL rst_write_data: got %02h expected 00", bus.write_data); end
      checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (streaming !== 1'b0)      begin errors++; $display("FAIL rst_streaming: got %b expected 0", streaming); end
      checks++; if (frame_cnt !== 8'h00)     begin errors++; $display("FAIL rst_frame_cnt: got %02h expected 00", frame_cnt); end
      checks++; if (sof_err !== 1'b0)        begin errors++; $display("FAIL rst_sof_err: got %b expected 0", sof_err); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_rgb_single();
      pix_q_t px;
      bit ok;
      got_q.delete(); got_t.delete(); exp_q.delete();
      mode = 2'd0;
      send_cmd(8'h02);
      repeat (3) @(posedge clk);
      px = {};
      for (int n = 0; n < int'(IM_X * IM_Y); n++) px.push_back(16'(16'h1234 + n));
      model_frame(0, px);
      push_frame(px);
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      repeat (12) @(negedge clk);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rgb_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rgb_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      if (got_t.size() >= 20) begin
         checks++;
         if (got_t[19] - got_t[0] !== 19) begin errors++; $display("FAIL rgb_throughput: got %0d cycles expected 19", got_t[19] - got_t[0]); end
      end
      checks++; if (frame_cnt !== 8'(exp_fc)) begin errors++; $display("FAIL rgb_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      checks++; if (streaming !== 1'b0)       begin errors++; $display("FAIL rgb_streaming: got %b expected 0", streaming); end
   endtask

   task automatic test_gray();
      pix_q_t px;
      bit ok;
      got_q.delete(); exp_q.delete();
      mode = 2'd1;
      send_cmd(8'h02);
      repeat (3) @(posedge clk);
      px = {16'hFFFF, 16'h0000, 16'hF800, 16'h07E0};
      for (int i = 4; i < int'(IM_X * IM_Y); i++) px.push_back(16'($urandom));
      model_frame(1, px);
      push_frame(px);
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL gray_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      repeat (12) @(negedge clk);
      checks++; if (got_q.size() !== 12) begin errors++; $display("FAIL gray_len: got %0d expected 12", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gray_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (frame_cnt !== 8'(exp_fc)) begin errors++; $display("FAIL gray_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_pattern_cont();
      pix_q_t px;
      bit ok;
      got_q.delete(); exp_q.delete();
      mode = 2'd2;
      send_cmd(8'h01);
      repeat (3) @(posedge clk);
      for (int f = 0; f < 2; f++) begin
         rand_frame(px);
         model_frame(2, px);
         push_frame(px);
      end
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL tp_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      send_cmd(8'h00);
      repeat (12) @(negedge clk);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL tp_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tp_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (streaming !== 1'b0)       begin errors++; $display("FAIL tp_streaming: got %b expected 0", streaming); end
      checks++; if (frame_cnt !== 8'(exp_fc)) begin errors++; $display("FAIL tp_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_sof_err();
      pix_q_t px, short_px;
      bit ok;
      got_q.delete(); exp_q.delete();
      mode = 2'd0;
      send_cmd(8'h01);
      repeat (3) @(posedge clk);
      rand_frame(px);
      short_px = px[0:4];
      model_frame(0, short_px);
      push_frame(short_px);
      rand_frame(px);
      model_frame(0, px);
      push_frame(px);
      wait_bytes(24, ok);
      send_cmd(8'h00);
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL sof_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      repeat (12) @(negedge clk);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sof_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (sof_err !== 1'b1)   begin errors++; $display("FAIL sof_err_set: got %b expected 1", sof_err); end
      checks++; if (streaming !== 1'b0) begin errors++; $display("FAIL sof_streaming: got %b expected 0", streaming); end
      send_cmd(8'h03);
      @(negedge clk);
      checks++; if (sof_err !== 1'b0)   begin errors++; $display("FAIL sof_err_clear: got %b expected 0", sof_err); end
   endtask

   task automatic test_stop_mode_change();
      pix_q_t px0, px1, px2;
      bit ok;
      got_q.delete(); exp_q.delete();
      mode = 2'd0;
      send_cmd(8'h01);
      repeat (3) @(posedge clk);
      rand_frame(px0); rand_frame(px1); rand_frame(px2);
      model_frame(0, px0);
      model_frame(1, px1);
      push_frame(px0); push_frame(px1); push_frame(px2);
      wait_bytes(6, ok);
      mode = 2'd1;
      wait_bytes(26, ok);
      send_cmd(8'h00);
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL stop_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      repeat (30) @(negedge clk);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stop_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stop_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (streaming !== 1'b0)       begin errors++; $display("FAIL stop_streaming: got %b expected 0", streaming); end
      checks++; if (frame_cnt !== 8'(exp_fc)) begin errors++; $display("FAIL stop_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
      src_q.delete();
   endtask

   task automatic test_stall();
      pix_q_t px;
      bit stalled;
      logic [7:0] held;
      int m;
      for (int t = 0; t < 3; t++) begin
         got_q.delete(); exp_q.delete();
         m = t;
         mode = 2'(m);
         rdy_rand = 1'b1;
         send_cmd(8'h02);
         repeat (3) @(posedge clk);
         rand_frame(px);
         model_frame(m, px);
         push_frame(px);
         stalled = 1'b0;
         held = '0;
         for (int c = 0; c < 3000 && got_q.size() < exp_q.size(); c++) begin
            @(negedge clk); #1;
            if (stalled) begin
               checks++;
               if (bus.write !== 1'b1 || bus.write_data !== held) begin
                  errors++;
                  $display("FAIL stall_hold: got write=%b data=%02h expected write=1 data=%02h", bus.write, bus.write_data, held);
               end
            end
            stalled = bus.write && !bus.wr_ready;
            held = bus.write_data;
         end
         rdy_rand = 1'b0;
         repeat (12) @(negedge clk);
         checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_async_reset();
      pix_q_t px;
      bit ok;
      got_q.delete(); exp_q.delete();
      mode = 2'd0;
      send_cmd(8'h01);
      repeat (3) @(posedge clk);
      rand_frame(px);
      push_frame(px);
      wait_bytes(7, ok);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.write !== 1'b0)      begin errors++; $display("FAIL arst_write: got %b expected 0", bus.write); end
      checks++; if (bus.write_data !== 8'h00) begin errors++; $display("FAIL arst_write_data: got %02h expected 00", bus.write_data); end
      checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL arst_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (streaming !== 1'b0)      begin errors++; $display("FAIL arst_streaming: got %b expected 0", streaming); end
      checks++; if (frame_cnt !== 8'h00)     begin errors++; $display("FAIL arst_frame_cnt: got %02h expected 00", frame_cnt); end
      src_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_fc = 0;
      got_q.delete(); exp_q.delete();
      mode = 2'd1;
      send_cmd(8'h02);
      repeat (3) @(posedge clk);
      rand_frame(px);
      model_frame(1, px);
      push_frame(px);
      wait_bytes(exp_q.size(), ok);
      checks++; if (!ok) begin errors++; $display("FAIL arst_resume_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      repeat (12) @(negedge clk);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL arst_resume_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL arst_resume_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_rgb_single();
      test_gray();
      test_pattern_cont();
      test_sof_err();
      test_stop_mode_change();
      test_stall();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
